iz_neuron_array: RTL

Time-multiplexed array of `N_NEURONS` Izhikevich neurons sharing one fixed-point update datapath. It is the parametrised successor to the single-neuron system.
- Per-neuron a/b/c/d parameters are loaded through a framed serial port.
- Per-neuron stimulus is written over an 8-bit bus.
- One neuron is updated per enabled cycle. A full sweep of all neurons is one simulation timestep, and it produces a registered spike vector plus an 8-bit membrane monitor.

---
 rtl/iz_pkg.sv | 37 +++
 rtl/iz_neuron_array_if.sv | 27 ++
 rtl/iz_param_deserializer.sv | 103 ++++++++++
 rtl/iz_neuron_array.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/iz_pkg.sv
// Shared constants, loader state encoding and saturation helper for the
// Izhikevich neuron array.
package iz_pkg;

  // Model constants in whole units; the datapath scales them by 2^FRAC.
  localparam int V_RESET    = -65;
  localparam int U_RESET    = -13;
  localparam int V_PEAK     = 30;
  localparam int C140       = 140;
  localparam int K004_NUM   = 41;
  localparam int K004_SHIFT = 10;

  // Serial frame layout: 8 index bits followed by a, b, c, d.
  localparam int IDX_BITS   = 8;

  // Width of the full-precision arithmetic intermediates.
  localparam int IW         = 64;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_INDEX = 2'd1,
    LD_PARAM = 2'd2
  } ld_state_e;

  // Clamp a wide signed value into the signed range of a width-bit word.
  function automatic logic signed [IW-1:0] sat_w(input logic signed [IW-1:0] x,
                                                  input int width);
    logic signed [IW-1:0] hi;
    logic signed [IW-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/iz_neuron_array_if.sv
// Control, loader, stimulus and monitor signals of the neuron array.
interface iz_neuron_array_if #(
  parameter int N_NEURONS = 8
) ();
  logic                 enable;
  logic                 load_mode;
  logic                 serial_data;
  logic                 stim_we;
  logic [7:0]           stim_addr;
  logic [7:0]           input_bus;
  logic [7:0]           mon_sel;
  logic [7:0]           output_bus;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 step_done;
  logic                 params_ready;
  logic                 load_error;

  modport master (
    output enable, load_mode, serial_data, stim_we, stim_addr, input_bus, mon_sel,
    input  output_bus, spike_vec, step_done, params_ready, load_error
  );

  modport slave (
    input  enable, load_mode, serial_data, stim_we, stim_addr, input_bus, mon_sel,
    output output_bus, spike_vec, step_done, params_ready, load_error
  );
endinterface

// File: rtl/iz_param_deserializer.sv
// Serial parameter loader: collects an 8-bit index and a/b/c/d, MSB first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LD_IDLE  | no frame; first load_mode=1 cycle captures index bit 7
//   LD_INDEX | shifting the remaining 7 index bits
//   LD_PARAM | shifting 4*WIDTH parameter bits; commit on the last one
//
// commit and a/b/c/d are combinational so the last bit lands in the
// parameter RAM on the same edge that samples it.
module iz_param_deserializer
  import iz_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_mode,
  input  logic                    serial_data,
  output logic                    commit,
  output logic [IDX_BITS-1:0]     index,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] d
);
  localparam int PBITS = 4 * WIDTH;
  localparam int CW    = $clog2(PBITS + 1);

  ld_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [PBITS-2:0]      shreg_q, shreg_d;
  logic [PBITS-1:0]      frame;

  // State register with bit down-counter and shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Next state: a low load_mode always aborts back to idle with the counter cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (!load_mode) begin
      state_d = LD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          idx_d   = {idx_q[IDX_BITS-2:0], serial_data};
          cnt_d   = CW'(IDX_BITS - 1);
          state_d = LD_INDEX;
        end
        LD_INDEX: begin
          idx_d = {idx_q[IDX_BITS-2:0], serial_data};
          if (cnt_q == CW'(1)) begin
            cnt_d   = CW'(PBITS);
            state_d = LD_PARAM;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        LD_PARAM: begin
          shreg_d = {shreg_q[PBITS-3:0], serial_data};
          if (cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = LD_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = LD_IDLE;
        end
      endcase
    end
  end

  // Outputs: commit on the final parameter bit, fields taken including that bit.
  always_comb begin
    commit = load_mode && (state_q == LD_PARAM) && (cnt_q == CW'(1));
    frame  = {shreg_q, serial_data};
    index  = idx_q;
    a      = frame[4*WIDTH-1 -: WIDTH];
    b      = frame[3*WIDTH-1 -: WIDTH];
    c      = frame[2*WIDTH-1 -: WIDTH];
    d      = frame[WIDTH-1 -: WIDTH];
  end
endmodule

// File: rtl/iz_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared datapath updates the
// neuron at the pointer each enabled cycle; a full sweep is one timestep.
module iz_neuron_array
  import iz_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int DT_SHIFT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  iz_neuron_array_if.slave bus
);
  localparam int PW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  localparam logic signed [WIDTH-1:0] V_RST_FX  = WIDTH'(V_RESET * (1 << FRAC));
  localparam logic signed [WIDTH-1:0] U_RST_FX  = WIDTH'(U_RESET * (1 << FRAC));
  localparam logic signed [IW-1:0]    V_PEAK_FX = IW'(V_PEAK) <<< FRAC;
  localparam logic signed [IW-1:0]    C140_FX   = IW'(C140) <<< FRAC;

  logic signed [WIDTH-1:0] v_q [N_NEURONS];
  logic signed [WIDTH-1:0] v_d [N_NEURONS];
  logic signed [WIDTH-1:0] u_q [N_NEURONS];
  logic signed [WIDTH-1:0] u_d [N_NEURONS];
  logic signed [WIDTH-1:0] pa_q [N_NEURONS];
  logic signed [WIDTH-1:0] pa_d [N_NEURONS];
  logic signed [WIDTH-1:0] pb_q [N_NEURONS];
  logic signed [WIDTH-1:0] pb_d [N_NEURONS];
  logic signed [WIDTH-1:0] pc_q [N_NEURONS];
  logic signed [WIDTH-1:0] pc_d [N_NEURONS];
  logic signed [WIDTH-1:0] pd_q [N_NEURONS];
  logic signed [WIDTH-1:0] pd_d [N_NEURONS];
  logic [7:0]              stim_q [N_NEURONS];
  logic [7:0]              stim_d [N_NEURONS];

  logic [N_NEURONS-1:0] loaded_q, loaded_d;
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 step_done_q, step_done_d;
  logic                 params_ready_q, params_ready_d;
  logic                 load_error_q, load_error_d;
  logic [7:0]           output_bus_q, output_bus_d;

  logic                    commit;
  logic [IDX_BITS-1:0]     ld_index;
  logic signed [WIDTH-1:0] ld_a, ld_b, ld_c, ld_d;

  logic signed [IW-1:0] vw, uw, iw, aw, bw, dw;
  logic signed [IW-1:0] sq, dv, bv, du, vn_w, un_w;
  logic signed [WIDTH-1:0] v_new, u_new;
  logic                    spike;

  iz_param_deserializer #(.WIDTH(WIDTH)) u_loader (
    .clk         (clk),
    .reset       (reset),
    .load_mode   (bus.load_mode),
    .serial_data (bus.serial_data),
    .commit      (commit),
    .index       (ld_index),
    .a           (ld_a),
    .b           (ld_b),
    .c           (ld_c),
    .d           (ld_d)
  );

  // Shared update datapath for the neuron at the pointer (old state, old params).
  always_comb begin
    vw    = IW'(v_q[ptr_q]);
    uw    = IW'(u_q[ptr_q]);
    iw    = IW'(stim_q[ptr_q]);
    aw    = IW'(pa_q[ptr_q]);
    bw    = IW'(pb_q[ptr_q]);
    dw    = IW'(pd_q[ptr_q]);
    sq    = (vw * vw) >>> FRAC;
    dv    = ((sq * IW'(K004_NUM)) >>> K004_SHIFT) + (vw * IW'(5)) + C140_FX - uw + (iw <<< FRAC);
    bv    = (bw * vw) >>> FRAC;
    du    = (aw * (bv - uw)) >>> FRAC;
    vn_w  = sat_w(vw + (dv >>> DT_SHIFT), WIDTH);
    un_w  = sat_w(uw + (du >>> DT_SHIFT), WIDTH);
    spike = (vn_w >= V_PEAK_FX);
    if (spike) begin
      v_new = pc_q[ptr_q];
      u_new = WIDTH'(sat_w(un_w + dw, WIDTH));
    end else begin
      v_new = WIDTH'(vn_w);
      u_new = WIDTH'(un_w);
    end
  end

  // Next state for neuron state, pointer, sweep bookkeeping, RAM writes and monitor.
  always_comb begin
    v_d          = v_q;
    u_d          = u_q;
    pa_d         = pa_q;
    pb_d         = pb_q;
    pc_d         = pc_q;
    pd_d         = pd_q;
    stim_d       = stim_q;
    loaded_d     = loaded_q;
    acc_d        = acc_q;
    ptr_d        = ptr_q;
    spike_vec_d  = spike_vec_q;
    step_done_d  = 1'b0;
    load_error_d = load_error_q;

    if (bus.enable) begin
      if (loaded_q[ptr_q]) begin
        v_d[ptr_q] = v_new;
        u_d[ptr_q] = u_new;
      end
      acc_d[ptr_q] = loaded_q[ptr_q] & spike;
      if (ptr_q == PW'(N_NEURONS - 1)) begin
        spike_vec_d = acc_d;
        acc_d       = '0;
        step_done_d = 1'b1;
        ptr_d       = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end

    if (bus.stim_we && ({1'b0, bus.stim_addr} < 9'(N_NEURONS)))
      stim_d[bus.stim_addr[PW-1:0]] = bus.input_bus;

    if (commit) begin
      if ({1'b0, ld_index} < 9'(N_NEURONS)) begin
        pa_d[ld_index[PW-1:0]]     = ld_a;
        pb_d[ld_index[PW-1:0]]     = ld_b;
        pc_d[ld_index[PW-1:0]]     = ld_c;
        pd_d[ld_index[PW-1:0]]     = ld_d;
        loaded_d[ld_index[PW-1:0]] = 1'b1;
      end else begin
        load_error_d = 1'b1;
      end
    end

    params_ready_d = &loaded_d;

    if ({1'b0, bus.mon_sel} < 9'(N_NEURONS))
      output_bus_d = v_q[bus.mon_sel[PW-1:0]][WIDTH-1 -: 8];
    else
      output_bus_d = 8'h00;
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= V_RST_FX;
        u_q[i]    <= U_RST_FX;
        pa_q[i]   <= '0;
        pb_q[i]   <= '0;
        pc_q[i]   <= '0;
        pd_q[i]   <= '0;
        stim_q[i] <= '0;
      end
      loaded_q       <= '0;
      acc_q          <= '0;
      ptr_q          <= '0;
      spike_vec_q    <= '0;
      step_done_q    <= 1'b0;
      params_ready_q <= 1'b0;
      load_error_q   <= 1'b0;
      output_bus_q   <= '0;
    end else begin
      v_q            <= v_d;
      u_q            <= u_d;
      pa_q           <= pa_d;
      pb_q           <= pb_d;
      pc_q           <= pc_d;
      pd_q           <= pd_d;
      stim_q         <= stim_d;
      loaded_q       <= loaded_d;
      acc_q          <= acc_d;
      ptr_q          <= ptr_d;
      spike_vec_q    <= spike_vec_d;
      step_done_q    <= step_done_d;
      params_ready_q <= params_ready_d;
      load_error_q   <= load_error_d;
      output_bus_q   <= output_bus_d;
    end
  end

  assign bus.output_bus   = output_bus_q;
  assign bus.spike_vec    = spike_vec_q;
  assign bus.step_done    = step_done_q;
  assign bus.params_ready = params_ready_q;
  assign bus.load_error   = load_error_q;
endmodule
